// File: rtl/data_mem_responder_pkg.sv
// Shared types and address-check helper for the MEM-stage data memory responder.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_LSB   = $clog2(WORD_BYTES);
  localparam int unsigned CHK_W      = 64;

  // Word-aligned and inside the backing array.
  function automatic logic addr_ok(input logic [CHK_W-1:0] addr, input int unsigned depth);
    logic [CHK_W-1:0] widx;
    widx = addr >> WORD_LSB;
    return (addr[WORD_LSB-1:0] == '0) && (widx < CHK_W'(depth));
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM-stage initiator and the data memory responder.
interface data_mem_responder_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              stall_m;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall_m
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall_m
  );
endinterface

// File: rtl/data_mem_responder_word_ram.sv
// Word-wide backing array: synchronous write, combinational read, contents not reset.
module word_ram #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with fixed wait states and MEM-stage stall.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CNT_LOAD = (LATENCY == 0) ? 0 : LATENCY - 1;

  mem_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              ready_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [ADDR_W-1:0] chk_addr;
  logic              chk_write;
  logic              chk_ok;
  logic [IDX_W-1:0]  ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] resp_data;

  // In IDLE the live bus payload is checked so a zero-latency build can respond next cycle.
  assign chk_addr  = (state == IDLE) ? bus.req_addr  : cap_addr;
  assign chk_write = (state == IDLE) ? bus.req_write : cap_write;
  assign chk_ok    = addr_ok(CHK_W'(chk_addr), DEPTH_WORDS);
  assign ram_addr  = chk_addr[WORD_LSB +: IDX_W];
  assign ram_we    = (state == RESP) && cap_write && chk_ok;
  assign resp_data = (chk_ok && !chk_write) ? ram_rdata : '0;

  word_ram #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (cap_wdata),
    .rdata (ram_rdata)
  );

  // Transaction FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      cap_write    <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            cap_write <= bus.req_write;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            ready_q   <= 1'b0;
            if (LATENCY == 0) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              rdata_q      <= resp_data;
              err_q        <= !chk_ok;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(CNT_LOAD);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= resp_data;
            err_q        <= !chk_ok;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state        <= IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          rdata_q      <= '0;
          err_q        <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          rdata_q      <= '0;
          err_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.stall_m    = bus.req_valid & ~resp_valid_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 main instance plus a LATENCY=0 build.
module tb_data_mem_responder;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 256;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  data_mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();
  data_mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) ifz ();

  data_mem_responder #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH), .LATENCY(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  data_mem_responder #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH), .LATENCY(0)
  ) dut_l0 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One LATENCY=2 transaction; from_resp drives the payload during the previous RESP cycle.
  task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_d, input logic exp_e, input logic hold,
                     input logic from_resp);
    int n;
    ifc.req_valid = 1'b1;
    ifc.req_write = w;
    ifc.req_addr  = a;
    ifc.req_wdata = d;
    if (from_resp) begin
      #1;
      check({tag, "_ready_in_resp"}, 64'(ifc.req_ready), 64'd0);
      @(posedge clk);
    end
    #1;
    check({tag, "_ready"}, 64'(ifc.req_ready), 64'd1);
    check({tag, "_stall_req"}, 64'(ifc.stall_m), 64'd1);
    step();
    n = 1;
    while (!ifc.resp_valid && n < 12) begin
      check({tag, "_stall_wait"}, 64'(ifc.stall_m), 64'd1);
      check({tag, "_ready_wait"}, 64'(ifc.req_ready), 64'd0);
      step();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd3);
    check({tag, "_rdata"}, 64'(ifc.resp_rdata), 64'(exp_d));
    check({tag, "_err"}, 64'(ifc.resp_err), 64'(exp_e));
    check({tag, "_stall_resp"}, 64'(ifc.stall_m), 64'd0);
    if (!hold) begin
      ifc.req_valid = 1'b0;
      step();
      check({tag, "_pulse"}, 64'(ifc.resp_valid), 64'd0);
      check({tag, "_ready_after"}, 64'(ifc.req_ready), 64'd1);
    end
  endtask

  // One LATENCY=0 transaction on the second instance.
  task automatic ztxn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_d, input logic exp_e);
    ifz.req_valid = 1'b1;
    ifz.req_write = w;
    ifz.req_addr  = a;
    ifz.req_wdata = d;
    #1;
    check({tag, "_ready"}, 64'(ifz.req_ready), 64'd1);
    check({tag, "_stall_req"}, 64'(ifz.stall_m), 64'd1);
    check({tag, "_rv_early"}, 64'(ifz.resp_valid), 64'd0);
    step();
    check({tag, "_rv"}, 64'(ifz.resp_valid), 64'd1);
    check({tag, "_rdata"}, 64'(ifz.resp_rdata), 64'(exp_d));
    check({tag, "_err"}, 64'(ifz.resp_err), 64'(exp_e));
    check({tag, "_stall_resp"}, 64'(ifz.stall_m), 64'd0);
    check({tag, "_ready_resp"}, 64'(ifz.req_ready), 64'd0);
    ifz.req_valid = 1'b0;
    step();
    check({tag, "_pulse"}, 64'(ifz.resp_valid), 64'd0);
    check({tag, "_ready_after"}, 64'(ifz.req_ready), 64'd1);
  endtask

  initial begin
    int n;
    ifc.req_valid = 1'b0;
    ifc.req_write = 1'b0;
    ifc.req_addr  = '0;
    ifc.req_wdata = '0;
    ifz.req_valid = 1'b0;
    ifz.req_write = 1'b0;
    ifz.req_addr  = '0;
    ifz.req_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_ready", 64'(ifc.req_ready), 64'd1);
    check("rst_rv", 64'(ifc.resp_valid), 64'd0);
    check("rst_rdata", 64'(ifc.resp_rdata), 64'd0);
    check("rst_err", 64'(ifc.resp_err), 64'd0);
    check("rst_stall", 64'(ifc.stall_m), 64'd0);

    // Basic store then load
    txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0);
    txn("ld10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);

    // Misaligned and out-of-range requests leave the array untouched
    txn("st0", 1'b1, 32'h0, 32'h11111111, 32'h0, 1'b0, 1'b0, 1'b0);
    txn("ld12", 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    txn("st402", 1'b1, 32'h402, 32'h55, 32'h0, 1'b1, 1'b0, 1'b0);
    txn("st400", 1'b1, 32'h400, 32'h66, 32'h0, 1'b1, 1'b0, 1'b0);
    txn("ld0", 0, 32'h0, 32'h0, 32'h11111111, 1'b0, 1'b0, 1'b0);

    // Back-to-back store/load pairs with req_valid held across responses
    for (int i = 0; i < 10; i++) begin
      txn("b2b_st", 1'b1, 32'h80 + 32'(i * 4), 32'hA5000000 | 32'(i), 32'h0, 1'b0, 1'b1, i != 0);
      txn("b2b_ld", 1'b0, 32'h80 + 32'(i * 4), 32'h0, 32'hA5000000 | 32'(i), 1'b0, i != 9, 1'b1);
    end

    // Payload change and req_valid drop after acceptance
    txn("st20", 1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    txn("st24", 1'b1, 32'h24, 32'h2424, 32'h0, 1'b0, 1'b0, 1'b0);
    ifc.req_valid = 1'b1;
    ifc.req_write = 1'b1;
    ifc.req_addr  = 32'h20;
    ifc.req_wdata = 32'h1;
    #1;
    check("drop_ready", 64'(ifc.req_ready), 64'd1);
    step();
    ifc.req_valid = 1'b0;
    ifc.req_write = 1'b0;
    ifc.req_addr  = 32'h24;
    ifc.req_wdata = 32'h99;
    #1;
    check("drop_stall", 64'(ifc.stall_m), 64'd0);
    n = 0;
    while (!ifc.resp_valid && n < 12) begin
      step();
      n++;
    end
    check("drop_lat", 64'(n), 64'd2);
    check("drop_err", 64'(ifc.resp_err), 64'd0);
    step();
    txn("ld20", 1'b0, 32'h20, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0);
    txn("ld24", 1'b0, 32'h24, 32'h0, 32'h2424, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a store
    txn("st30", 1'b1, 32'h30, 32'h3030, 32'h0, 1'b0, 1'b0, 1'b0);
    ifc.req_valid = 1'b1;
    ifc.req_write = 1'b1;
    ifc.req_addr  = 32'h30;
    ifc.req_wdata = 32'hAA;
    step();
    ifc.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("mrst_ready", 64'(ifc.req_ready), 64'd1);
    check("mrst_rv", 64'(ifc.resp_valid), 64'd0);
    check("mrst_rdata", 64'(ifc.resp_rdata), 64'd0);
    check("mrst_err", 64'(ifc.resp_err), 64'd0);
    check("mrst_stall", 64'(ifc.stall_m), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mrst_no_rv", 64'(ifc.resp_valid), 64'd0);
    end
    reset = 1'b1;
    step();
    txn("ld30", 1'b0, 32'h30, 32'h0, 32'h3030, 1'b0, 1'b0, 1'b0);

    // Zero-latency build
    ztxn("z_st40", 1'b1, 32'h40, 32'h77, 32'h0, 1'b0);
    ztxn("z_ld40", 1'b0, 32'h40, 32'h0, 32'h77, 1'b0);
    ztxn("z_ld41", 1'b0, 32'h41, 32'h0, 32'h0, 1'b1);
    ztxn("z_st_oor", 1'b1, 32'h800, 32'h5, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
